prg_rom_loader: RTL and testbench

- Upstream feeder for the 32 KB x8 single-port PRG RAM in the NES core.
- Consumes a byte stream carrying an iNES image (from the UART/SD byte source), skips the header and captures the PRG size from it.
- Writes PRG bytes sequentially into the RAM, then hands the RAM over to the CPU read path, with 16 KB mirroring for NROM-128 images.

---
 rtl/prg_rom_loader.sv | 156 +++++++++++++++
 tb/tb_prg_rom_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_rom_loader.sv
// iNES PRG loader: skips the header, streams PRG bytes into the 32 KB PRG RAM, then serves CPU reads.
// Optional build macro PRG_LOADER_CHECKSUM_EN adds a 16-bit wrapping sum of the PRG bytes written.
module prg_rom_loader #(
    parameter int HDR_BYTES     = 16,
    parameter int SIZE_IDX      = 4,
    parameter int DEFAULT_UNITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        cpu_rd,
    input  logic [14:0] cpu_addr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic        ram_ce,
    output logic        ram_oce,
    output logic        ram_wre,
    output logic [14:0] ram_ad,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        loading,
    output logic        done,
    output logic        error,
    output logic        mirror16,
    output logic [15:0] checksum
);

    localparam int HCW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam logic [HCW-1:0] HDR_LAST  = HCW'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);
    localparam logic [HCW-1:0] SIZE_POS  = HCW'(SIZE_IDX);
    localparam logic [HCW-1:0] HCNT_ONE  = HCW'(1);
    localparam logic [7:0]     DEF_UNITS = 8'(DEFAULT_UNITS);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_DONE, S_ERROR} state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [7:0]     units_q, units_d;
    logic [14:0]    addr_q, addr_d;
    logic           mirror16_q, mirror16_d;
    logic           in_ready_q, in_ready_d;
    logic           cpu_rvalid_q, cpu_rvalid_d;
    logic           accept;
    logic           last_byte;
    logic [7:0]     units_now;

    // A byte offered alongside load_start is refused even though in_ready may still read 1.
    assign accept    = in_valid & in_ready_q & ~load_start;
    assign last_byte = mirror16_q ? (addr_q[13:0] == 14'h3FFF) : (addr_q == 15'h7FFF);

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        units_d      = units_q;
        addr_d       = addr_q;
        mirror16_d   = mirror16_q;
        cpu_rvalid_d = 1'b0;
        units_now    = units_q;
        ram_ce       = 1'b0;
        ram_wre      = 1'b0;
        ram_ad       = 15'h0000;
        ram_din      = 8'h00;
        if (load_start) begin
            hdr_cnt_d  = '0;
            addr_d     = 15'h0000;
            mirror16_d = 1'b0;
            units_d    = 8'h00;
            if (HDR_BYTES == 0) begin
                state_d    = S_DATA;
                units_d    = DEF_UNITS;
                mirror16_d = (DEF_UNITS == 8'd1);
            end else begin
                state_d = S_HEADER;
            end
        end else begin
            case (state_q)
                S_HEADER: if (accept) begin
                    hdr_cnt_d = hdr_cnt_q + HCNT_ONE;
                    if (hdr_cnt_q == SIZE_POS) units_now = in_data;
                    units_d = units_now;
                    if (hdr_cnt_q == HDR_LAST) begin
                        if (units_now == 8'd1) begin
                            mirror16_d = 1'b1;
                            state_d    = S_DATA;
                        end else if (units_now == 8'd2) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                end
                S_DATA: if (accept) begin
                    ram_ce  = 1'b1;
                    ram_wre = 1'b1;
                    ram_ad  = addr_q;
                    ram_din = in_data;
                    // Address is held on the final byte so it never wraps.
                    if (last_byte) state_d = S_DONE;
                    else           addr_d  = addr_q + 15'd1;
                end
                S_DONE: if (cpu_rd) begin
                    ram_ce       = 1'b1;
                    ram_ad       = {cpu_addr[14] & ~mirror16_q, cpu_addr[13:0]};
                    cpu_rvalid_d = 1'b1;
                end
                default: ;
            endcase
        end
        in_ready_d = (state_d == S_HEADER) || (state_d == S_DATA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hdr_cnt_q    <= '0;
            units_q      <= 8'h00;
            addr_q       <= 15'h0000;
            mirror16_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            units_q      <= units_d;
            addr_q       <= addr_d;
            mirror16_q   <= mirror16_d;
            in_ready_q   <= in_ready_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

`ifdef PRG_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           checksum_q <= 16'h0000;
        else if (load_start) checksum_q <= 16'h0000;
        else if (ram_wre)    checksum_q <= checksum_q + {8'h00, ram_din};
    end
    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign in_ready   = in_ready_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = ram_dout;
    assign mirror16   = mirror16_q;
    assign ram_oce    = 1'b1;
    assign loading    = (state_q == S_HEADER) || (state_q == S_DATA);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_prg_rom_loader.sv
// Directed bench for prg_rom_loader with a behavioural 32 KB PRG RAM (1-cycle read, write-through).
module tb_prg_rom_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        cpu_rd = 1'b0;
    logic [14:0] cpu_addr = 15'h0000;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        ram_ce, ram_oce, ram_wre;
    logic [14:0] ram_ad;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = 8'h00;
    logic        loading, done, error, mirror16;
    logic [15:0] checksum;

    int checks = 0;
    int failures = 0;
    int wre_cnt = 0;
    int wre_snap;
    logic [7:0] mem [0:32767];

    always #5 clk = ~clk;

    prg_rom_loader dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .loading(loading), .done(done), .error(error), .mirror16(mirror16), .checksum(checksum)
    );

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                mem[ram_ad] <= ram_din;
                ram_dout    <= ram_din;
            end else begin
                ram_dout <= mem[ram_ad];
            end
        end
        if (ram_wre) wre_cnt <= wre_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic send_header(input logic [7:0] units);
        for (int i = 0; i < 16; i++) send((i == 4) ? units : (8'hE0 | 8'(i)));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h99;
        #1 chk("start_no_write", 16'(ram_wre), 16'd0);
        @(negedge clk);
        load_start = 1'b0;
        in_valid   = 1'b0;
        #1;
        chk("start_loading", 16'(loading), 16'd1);
        chk("start_in_ready", 16'(in_ready), 16'd1);
        chk("start_mirror16", 16'(mirror16), 16'd0);
    endtask

    task automatic cpu_read(input logic [14:0] a, input logic [14:0] exp_ad, input logic [7:0] exp_d);
        @(negedge clk);
        cpu_rd   = 1'b1;
        cpu_addr = a;
        #1;
        chk("rd_ram_ad", 16'(ram_ad), 16'(exp_ad));
        chk("rd_ram_ce", 16'(ram_ce), 16'd1);
        chk("rd_ram_wre", 16'(ram_wre), 16'd0);
        @(negedge clk);
        cpu_rd = 1'b0;
        #1;
        chk("rd_rvalid", 16'(cpu_rvalid), 16'd1);
        chk("rd_rdata", 16'(cpu_rdata), 16'(exp_d));
    endtask

    initial begin
        // Reset and idle outputs
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {in_ready, cpu_rvalid, mirror16, loading, done, error, ram_ce, ram_wre},
            16'h0000);
        chk("rst_ram_ad", 16'(ram_ad), 16'h0000);
        chk("rst_ram_din", 16'(ram_din), 16'h0000);
        chk("rst_checksum", checksum, 16'h0000);
        chk("rst_oce", 16'(ram_oce), 16'd1);

        // 32 KB image, data = addr & 0xFF
        pulse_start();
        send_header(8'd2);
        for (int i = 0; i < 32768; i++) begin
            send(8'(i));
            if (i == 0 || i == 32767) begin
                #1;
                chk("d32_wre", 16'(ram_wre), 16'd1);
                chk("d32_ad", 16'(ram_ad), 16'(i));
                chk("d32_din", 16'(ram_din), 16'(i & 255));
            end
        end
        @(negedge clk);
        in_data = 8'hC3;
        #1;
        chk("d32_done", 16'(done), 16'd1);
        chk("d32_mirror16", 16'(mirror16), 16'd0);
        chk("d32_in_ready", 16'(in_ready), 16'd0);
        chk("d32_no_extra_wre", 16'(ram_wre), 16'd0);
`ifdef PRG_LOADER_CHECKSUM_EN
        chk("d32_checksum", checksum, 16'hC000);
`else
        chk("d32_checksum", checksum, 16'h0000);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        cpu_read(15'h7FFF, 15'h7FFF, 8'hFF);
        // Back-to-back reads
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_addr = 15'h1234;
        @(negedge clk);
        cpu_addr = 15'h4321;
        #1;
        chk("b2b_rvalid0", 16'(cpu_rvalid), 16'd1);
        chk("b2b_rdata0", 16'(cpu_rdata), 16'h0034);
        @(negedge clk);
        cpu_rd = 1'b0;
        #1;
        chk("b2b_rvalid1", 16'(cpu_rvalid), 16'd1);
        chk("b2b_rdata1", 16'(cpu_rdata), 16'h0021);
        @(negedge clk);
        #1 chk("b2b_rvalid_off", 16'(cpu_rvalid), 16'd0);

        // 16 KB image of 0xA5, mirrored reads
        pulse_start();
        send_header(8'd1);
        for (int i = 0; i < 16384; i++) send(8'hA5);
        @(negedge clk);
        in_data = 8'h77;
        #1;
        chk("d16_done", 16'(done), 16'd1);
        chk("d16_mirror16", 16'(mirror16), 16'd1);
        chk("d16_in_ready", 16'(in_ready), 16'd0);
        @(negedge clk);
        #1 chk("d16_in_ready_hold", 16'(in_ready), 16'd0);
`ifdef PRG_LOADER_CHECKSUM_EN
        chk("d16_checksum", checksum, 16'h4000);
`else
        chk("d16_checksum", checksum, 16'h0000);
`endif
        in_valid = 1'b0;
        cpu_read(15'h4000, 15'h0000, 8'hA5);
        cpu_read(15'h0000, 15'h0000, 8'hA5);
        cpu_read(15'h7FFF, 15'h3FFF, 8'hA5);
        // Read in DONE immediately followed by load_start
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_addr = 15'h4001;
        @(negedge clk);
        cpu_rd = 1'b0;
        load_start = 1'b1;
        #1;
        chk("rd_then_start_rvalid", 16'(cpu_rvalid), 16'd1);
        @(negedge clk);
        load_start = 1'b0;
        wre_snap = wre_cnt;

        // Header with zero units -> ERROR
        send_header(8'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("err_error", 16'(error), 16'd1);
        chk("err_in_ready", 16'(in_ready), 16'd0);
        chk("err_loading", 16'(loading), 16'd0);
        chk("err_no_writes", 16'(wre_cnt - wre_snap), 16'd0);
        cpu_rd = 1'b1;
        cpu_addr = 15'h0010;
        #1 chk("err_rd_ce", 16'(ram_ce), 16'd0);
        @(negedge clk);
        cpu_rd = 1'b0;
        #1 chk("err_rd_rvalid", 16'(cpu_rvalid), 16'd0);
        pulse_start();
        chk("err_cleared", 16'(error), 16'd0);

        // Restart mid-DATA
        send_header(8'd2);
        for (int i = 0; i < 100; i++) send(8'h10 + 8'(i));
        pulse_start();
        send_header(8'd2);
        #1 chk("restart_hdr_no_wre", 16'(ram_wre), 16'd0);
        send(8'h37);
        #1;
        chk("restart_wre", 16'(ram_wre), 16'd1);
        chk("restart_ad", 16'(ram_ad), 16'h0000);
        chk("restart_din", 16'(ram_din), 16'h0037);
        chk("restart_done", 16'(done), 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
`ifdef PRG_LOADER_CHECKSUM_EN
        chk("restart_checksum", checksum, 16'h0037);
`else
        chk("restart_checksum", checksum, 16'h0000);
`endif

        // Asynchronous reset mid-load
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", {in_ready, loading, done, error, mirror16, ram_wre}, 16'h0000);
        chk("rst_mid_checksum", checksum, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
